// File: rtl/tick_meter_pkg.sv
// Shared types and default constants for the tick period meter.
package tick_meter_pkg;

  // Default counter / measurement width.
  localparam int unsigned CNT_W_DEF   = 32;
  // Default loss-of-signal limit in clk cycles (one second at 100 MHz).
  localparam int unsigned TIMEOUT_DEF = 100_000_000;

  // Measurement FSM states.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser chain plus one history flop for an asynchronous input.
// Produces the synchronised level and single-cycle rise/fall strobes.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic synced,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the raw input through the metastability chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  // Remember the previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~hist_q;
  assign fall   = ~synced & hist_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles, and flags loss of signal when no rising edge arrives in time.
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic rise;
  logic fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(tick_in),
    .synced (),
    .rise   (rise),
    .fall   (fall)
  );

  // Cycle counter: restarts at 1 on every rise, saturates at the timeout limit.
  always_comb begin
    if (rise) begin
      cnt_d = ONE_C;
    end else if (cnt_q >= TIMEOUT_C) begin
      cnt_d = TIMEOUT_C;
    end else begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a rise arms measurement, a silent timeout disarms it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (!rise && !fall && (cnt_q == TIMEOUT_C)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: rise beats fall beats timeout, so a rise landing on the limit still counts.
  always_comb begin
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (rise) timeout_d = 1'b0;
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end else if (fall) begin
          high_d = cnt_q;
        end else if (cnt_q == TIMEOUT_C) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule
